lcd_cmd_driver: RTL and testbench

Downstream consumer of the 32-bit LCD control register in the memory-mapped I/O block of the single-cycle RISC-V core. Converts software-written command words into HD44780-compatible write cycles: setup, enable pulse, hold, and command-dependent execution wait. Holds one pending command while a write cycle is in progress and flags overruns. Drives the board LCD pins directly.

---
 rtl/lcd_cmd_driver.sv | 205 ++++++++++++++++++++
 tb/tb_lcd_cmd_driver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_driver.sv
// HD44780 write-cycle sequencer driven by the memory-mapped LCD control word.
// Runs setup / enable pulse / hold / execution wait and keeps one command queued.
module lcd_cmd_driver #(
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 16,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 80000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun
);

    localparam int T_MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_EXEC_LONG) ? T_MAX_C : T_EXEC_LONG;
    localparam int CW      = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP);
    localparam logic [CW-1:0] C_PULSE = CW'(T_PULSE);
    localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD);
    localparam logic [CW-1:0] C_EXEC  = CW'(T_EXEC);
    localparam logic [CW-1:0] C_LONG  = CW'(T_EXEC_LONG);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [8:0]      act_cmd_q, act_cmd_d;   // {RS, DATA}
    logic [8:0]      pend_cmd_q, pend_cmd_d;
    logic            pend_vld_q, pend_vld_d;
    logic            go_q;
    logic            en_q, en_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;
    logic            on_q, blon_q;

    logic            req;
    logic [8:0]      word_cmd;
    logic            cnt_last;
    logic            is_long;
    logic            exec_end;
    logic            drain;
    logic            accept_pend;
    logic            unused_word_bits;

    assign unused_word_bits = ^{i_lcd_word[29:12], i_lcd_word[9]};

    assign req      = i_lcd_word[10] & ~go_q;
    assign word_cmd = {i_lcd_word[8], i_lcd_word[7:0]};
    assign cnt_last = (cnt_q == C_ONE);
    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    assign is_long  = ~act_cmd_q[8] && ((act_cmd_q[7:0] == 8'h01) ||
                                        (act_cmd_q[7:0] == 8'h02) ||
                                        (act_cmd_q[7:0] == 8'h03));
    assign exec_end = (state_q == S_EXEC) && cnt_last;
    // Pending leaves the buffer either at the end of EXEC or, if it was filled
    // during the final EXEC cycle, from IDLE on the following cycle.
    assign drain    = pend_vld_q && ((state_q == S_IDLE) || exec_end);
    assign accept_pend = req && ((state_q != S_IDLE) || pend_vld_q) &&
                         (!pend_vld_q || drain);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_cmd_d  = act_cmd_q;
        pend_cmd_d = pend_cmd_q;
        pend_vld_d = pend_vld_q;
        ovr_d      = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (pend_vld_q) begin
                    state_d   = S_SETUP;
                    cnt_d     = C_SETUP;
                    act_cmd_d = pend_cmd_q;
                end else if (req) begin
                    state_d   = S_SETUP;
                    cnt_d     = C_SETUP;
                    act_cmd_d = word_cmd;
                end
            end
            S_SETUP: begin
                if (cnt_last) begin
                    state_d = S_PULSE;
                    cnt_d   = C_PULSE;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_last) begin
                    state_d = S_HOLD;
                    cnt_d   = C_HOLD;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_last) begin
                    state_d = S_EXEC;
                    cnt_d   = is_long ? C_LONG : C_EXEC;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            S_EXEC: begin
                if (cnt_last) begin
                    if (pend_vld_q) begin
                        state_d   = S_SETUP;
                        cnt_d     = C_SETUP;
                        act_cmd_d = pend_cmd_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (drain) begin
            pend_vld_d = 1'b0;
        end
        if (accept_pend) begin
            pend_cmd_d = word_cmd;
            pend_vld_d = 1'b1;
        end

        // A drop on the same cycle as a clear leaves the flag set.
        if (i_lcd_word[11]) begin
            ovr_d = 1'b0;
        end
        if (req && pend_vld_q && !drain) begin
            ovr_d = 1'b1;
        end
    end

    assign en_d   = (state_d == S_PULSE);
    assign done_d = (state_d == S_EXEC) && (cnt_d == C_ONE);
    assign busy_d = (state_d != S_IDLE) || pend_vld_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            act_cmd_q  <= '0;
            pend_cmd_q <= '0;
            pend_vld_q <= 1'b0;
            go_q       <= 1'b1;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            on_q       <= 1'b0;
            blon_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_cmd_q  <= act_cmd_d;
            pend_cmd_q <= pend_cmd_d;
            pend_vld_q <= pend_vld_d;
            go_q       <= i_lcd_word[10];
            en_q       <= en_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            on_q       <= i_lcd_word[31];
            blon_q     <= i_lcd_word[30];
        end
    end

    assign o_lcd_data = act_cmd_q[7:0];
    assign o_lcd_rs   = act_cmd_q[8];
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_blon = blon_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Bench for lcd_cmd_driver: transaction-timeline reference model compared every
// cycle, directed scenarios with literal timing expectations, then random traffic.
module tb_lcd_cmd_driver;

    localparam int TS = 2;
    localparam int TP = 3;
    localparam int TH = 2;
    localparam int TE = 5;
    localparam int TL = 20;

    logic        clk;
    logic        rst_n;
    logic [31:0] word;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic        busy, done, overrun;

    lcd_cmd_driver #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LONG(TL)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_lcd_word (word),
        .o_lcd_data (lcd_data),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_en   (lcd_en),
        .o_lcd_on   (lcd_on),
        .o_lcd_blon (lcd_blon),
        .o_busy     (busy),
        .o_done     (done),
        .o_overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: the active command is described by its start and length;
    // each output is a function of how far into the transaction we are.
    logic       m_act;
    int         m_el;
    int         m_len;
    logic [8:0] m_last;
    logic [8:0] m_pq[$];
    logic       m_ovr, m_go, m_on, m_blon;

    // Observation trackers for the literal expectations.
    int   en_rise, en_cnt, done_first, done_last, busy_fall, d32_cyc;
    logic seen33, prev_en, prev_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_act  = 1'b0;
        m_el   = 0;
        m_len  = 0;
        m_last = '0;
        m_pq.delete();
        m_ovr  = 1'b0;
        m_go   = 1'b1;
        m_on   = 1'b0;
        m_blon = 1'b0;
    endtask

    task automatic model_start(input logic [8:0] cmd);
        logic long_cmd;
        long_cmd = (cmd[8] == 1'b0) && (cmd[7:0] >= 8'h01) && (cmd[7:0] <= 8'h03);
        m_act  = 1'b1;
        m_el   = 0;
        m_len  = TS + TP + TH + (long_cmd ? TL : TE);
        m_last = cmd;
    endtask

    task automatic model_step(input logic [31:0] w);
        logic       req, ending, ovr_set;
        logic [8:0] cmd;
        req     = w[10] && !m_go;
        cmd     = {w[8], w[7:0]};
        m_go    = w[10];
        m_on    = w[31];
        m_blon  = w[30];
        ovr_set = 1'b0;
        ending  = m_act && (m_el == m_len - 1);
        if (m_act && !ending) begin
            m_el++;
            if (req) begin
                if (m_pq.size() == 0) m_pq.push_back(cmd);
                else ovr_set = 1'b1;
            end
        end else if (m_pq.size() > 0) begin
            model_start(m_pq.pop_front());
            if (req) m_pq.push_back(cmd);
        end else if (ending) begin
            m_act = 1'b0;
            if (req) m_pq.push_back(cmd);
        end else if (req) begin
            model_start(cmd);
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (w[11]) m_ovr = 1'b0;
    endtask

    task automatic check_cycle();
        logic exp_en, exp_done, exp_busy;
        exp_en   = m_act && (m_el >= TS) && (m_el < TS + TP);
        exp_done = m_act && (m_el == m_len - 1);
        exp_busy = m_act || (m_pq.size() > 0);
        chk("data",    32'(lcd_data), 32'(m_last[7:0]));
        chk("rs",      32'(lcd_rs),   32'(m_last[8]));
        chk("rw",      32'(lcd_rw),   32'(1'b0));
        chk("en",      32'(lcd_en),   32'(exp_en));
        chk("done",    32'(done),     32'(exp_done));
        chk("busy",    32'(busy),     32'(exp_busy));
        chk("overrun", 32'(overrun),  32'(m_ovr));
        chk("on",      32'(lcd_on),   32'(m_on));
        chk("blon",    32'(lcd_blon), 32'(m_blon));
        if (lcd_en && !prev_en) en_rise = cyc;
        if (lcd_en) en_cnt++;
        if (done) begin
            if (done_first < 0) done_first = cyc;
            done_last = cyc;
        end
        if (!busy && prev_busy) busy_fall = cyc;
        if (lcd_data == 8'h33) seen33 = 1'b1;
        if (lcd_data == 8'h32 && d32_cyc < 0) d32_cyc = cyc;
        prev_en   = lcd_en;
        prev_busy = busy;
    endtask

    task automatic clear_track();
        en_rise = -1; en_cnt = 0; done_first = -1; done_last = -1;
        busy_fall = -1; d32_cyc = -1; seen33 = 1'b0;
    endtask

    // Called just after a falling edge: drive, clock, then check mid-low-phase.
    task automatic tick(input logic [31:0] w);
        word = w;
        @(posedge clk);
        if (rst_n) model_step(w);
        else model_reset();
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(32'h0);
    endtask

    int go_cyc;
    logic [31:0] rw;
    logic        rgo;

    initial begin
        rst_n = 1'b0;
        word  = 32'h0;
        prev_en = 1'b0; prev_busy = 1'b0;
        model_reset();
        clear_track();
        @(negedge clk);
        check_cycle();
        tick(32'h0000_0400);
        tick(32'h0);
        rst_n = 1'b1;
        idle_ticks(3);

        // Single data write 'A'.
        clear_track();
        go_cyc = cyc;
        tick(32'h0000_0541);
        idle_ticks(20);
        chk("wr_en_start", 32'(en_rise - go_cyc), 32'd3);
        chk("wr_en_len",   32'(en_cnt), 32'd3);
        chk("wr_done",     32'(done_last - go_cyc), 32'd12);
        chk("wr_busy_off", 32'(busy_fall - go_cyc), 32'd13);
        chk("wr_data",     32'(lcd_data), 32'h41);
        chk("wr_rs",       32'(lcd_rs), 32'd1);

        // Clear display then a normal command.
        clear_track();
        go_cyc = cyc;
        tick(32'h0000_0401);
        idle_ticks(35);
        chk("clr_done", 32'(done_last - go_cyc), 32'd27);
        clear_track();
        go_cyc = cyc;
        tick(32'h0000_0404);
        idle_ticks(20);
        chk("ent_done", 32'(done_last - go_cyc), 32'd12);

        // Back-to-back queueing.
        clear_track();
        tick(32'h0000_0531);
        idle_ticks(3);
        tick(32'h0000_0532);
        idle_ticks(35);
        chk("b2b_second", 32'(d32_cyc - done_first), 32'd1);
        chk("b2b_en_len", 32'(en_cnt), 32'd6);
        chk("b2b_ovr",    32'(overrun), 32'd0);

        // Overrun: third command inside the first transaction is dropped.
        clear_track();
        tick(32'h0000_0531);
        tick(32'h0);
        tick(32'h0000_0532);
        tick(32'h0);
        tick(32'h0000_0533);
        idle_ticks(35);
        chk("ovr_dropped", 32'(seen33), 32'd0);
        chk("ovr_en_len",  32'(en_cnt), 32'd6);
        chk("ovr_flag",    32'(overrun), 32'd1);
        tick(32'h0000_0800);
        chk("ovr_clear",   32'(overrun), 32'd0);

        // Reset asserted during PULSE.
        clear_track();
        tick(32'h0000_0541);
        tick(32'h0000_0541);
        tick(32'h0000_0541);
        chk("rst_in_pulse", 32'(lcd_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_en_async", 32'(lcd_en), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_data",     32'(lcd_data), 32'd0);
        @(negedge clk);
        check_cycle();
        tick(32'h0000_0400);
        rst_n = 1'b1;
        clear_track();
        for (int i = 0; i < 6; i++) tick(32'h0000_0400);
        chk("rst_go_held", 32'(en_cnt), 32'd0);
        chk("rst_no_busy", 32'(busy), 32'd0);
        tick(32'h0);
        tick(32'h0000_0400);
        chk("rst_retrigger", 32'(busy), 32'd1);
        idle_ticks(35);

        // Power and backlight pass-through.
        clear_track();
        tick(32'hC000_0000);
        chk("pwr_on",   32'(lcd_on), 32'd1);
        chk("pwr_blon", 32'(lcd_blon), 32'd1);
        idle_ticks(5);
        chk("pwr_no_en", 32'(en_cnt), 32'd0);

        // Random traffic against the model.
        rgo = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            rw = $urandom;
            if ($urandom_range(0, 5) == 0) rgo = ~rgo;
            rw[10] = rgo;
            rw[11] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rw[8]   = 1'b0;
                rw[7:0] = 8'($urandom_range(1, 3));
            end
            tick(rw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
